// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-channel debounce FSM
// states and the channel index assignment used on the held bus.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  localparam int P1           = 0;
  localparam int P2           = 1;
  localparam int START        = 2;
  localparam int NUM_CHANNELS = 3;

endpackage

// File: rtl/button_channel.sv
// One debounced pushbutton: polarity normalise, two-flop synchroniser,
// press/release stability FSM with a clear-on-entry counter, registered pulse.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic pulse_o,
  output logic held_o
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            norm;
  logic            sync1_q, sync2_q;
  btn_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            held_q, held_d;

  assign norm = (ACTIVE_LOW != 0) ? ~raw_i : raw_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= norm;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  // Every state change clears the counter, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == REL_CHK);
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Three independent debounced buttons (player 1, player 2, start) producing
// one-cycle press pulses and debounced held levels for the game FSM.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       p1_raw,
  input  logic       p2_raw,
  input  logic       start_raw,
  output logic       player1,
  output logic       player2,
  output logic       start,
  output logic [2:0] held
);

  logic [NUM_CHANNELS-1:0] rawVec;
  logic [NUM_CHANNELS-1:0] pulseVec;

  assign rawVec[P1]    = p1_raw;
  assign rawVec[P2]    = p2_raw;
  assign rawVec[START] = start_raw;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk_i  (clk),
      .rst_ni (clr),
      .raw_i  (rawVec[i]),
      .pulse_o(pulseVec[i]),
      .held_o (held[i])
    );
  end

  assign player1 = pulseVec[P1];
  assign player2 = pulseVec[P2];
  assign start   = pulseVec[START];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1:
// stimulus queues expected pulse events, a negedge monitor matches them.
module tb_button_conditioner;

  localparam int DEB = 4;

  typedef struct {
    int         edgeNo;
    logic [2:0] mask;
  } expEvt_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       p1_raw, p2_raw, start_raw;
  logic       player1, player2, start;
  logic [2:0] held;

  int      edgeCount = 0;
  int      checks    = 0;
  int      errors    = 0;
  expEvt_t expQ[$];
  expEvt_t monEvt;
  logic [2:0] monObs;
  int      kEdge;
  logic    seenHeld;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .p1_raw   (p1_raw),
    .p2_raw   (p2_raw),
    .start_raw(start_raw),
    .player1  (player1),
    .player2  (player2),
    .start    (start),
    .held     (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  // Monitor: flag expected pulses whose edge has passed unseen, then match
  // any observed pulse against the oldest expected event.
  always @(negedge clk) begin
    monObs = {start, player2, player1};
    while (expQ.size() > 0 && expQ[0].edgeNo < edgeCount) begin
      checks++;
      errors++;
      $display("[TB] FAIL missedPulse: expected mask %b after edge %0d, not seen (now edge %0d)",
               expQ[0].mask, expQ[0].edgeNo, edgeCount);
      void'(expQ.pop_front());
    end
    if (monObs != 3'b000) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedPulse: got mask %b after edge %0d, required none",
                 monObs, edgeCount);
      end else begin
        monEvt = expQ.pop_front();
        if (monEvt.edgeNo != edgeCount || monEvt.mask != monObs) begin
          errors++;
          $display("[TB] FAIL pulseMatch: got mask %b after edge %0d, required mask %b after edge %0d",
                   monObs, edgeCount, monEvt.mask, monEvt.edgeNo);
        end
      end
    end
  end

  task automatic applyStimulus(input logic pressP1, input logic pressP2, input logic pressSt);
    p1_raw    = ~pressP1;
    p2_raw    = ~pressP2;
    start_raw = ~pressSt;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b (edge %0d)", name, actual, required, edgeCount);
    end
  endtask

  task automatic pushExp(input int edgeNo, input logic [2:0] mask);
    expEvt_t e;
    e.edgeNo = edgeNo;
    e.mask   = mask;
    expQ.push_back(e);
  endtask

  task automatic waitToEdge(input int n);
    while (edgeCount < n) @(negedge clk);
  endtask

  initial begin
    clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset state
    checkOutput("resetPulses", {start, player2, player1}, 3'b000);
    checkOutput("resetHeld", held, 3'b000);
    @(negedge clk);
    clr = 1'b1;

    // Clean press on p1 before edge 10
    waitToEdge(9);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushExp(16, 3'b001);
    waitToEdge(15);
    checkOutput("cleanHeldBefore", held, 3'b000);
    waitToEdge(16);
    checkOutput("cleanHeldAt16", held, 3'b001);
    waitToEdge(22);
    applyStimulus(1'b0, 1'b0, 1'b0);
    kEdge = edgeCount + 1;
    waitToEdge(kEdge + 2 + DEB - 1);
    checkOutput("releaseStillHeld", held, 3'b001);
    waitToEdge(kEdge + 2 + DEB);
    checkOutput("releaseDone", held, 3'b000);

    // Bounce reject on p2: 3 low, 2 high, four times
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) begin
        @(negedge clk);
        checkOutput("bounceHeld", held, 3'b000);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (2) begin
        @(negedge clk);
        checkOutput("bounceHeld", held, 3'b000);
      end
    end
    repeat (8) begin
      @(negedge clk);
      checkOutput("bounceSettle", held, 3'b000);
    end

    // Simultaneous p1 + p2
    applyStimulus(1'b1, 1'b1, 1'b0);
    kEdge = edgeCount + 1;
    pushExp(kEdge + 2 + DEB, 3'b011);
    waitToEdge(kEdge + 2 + DEB);
    checkOutput("simulHeld", held, 3'b011);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("simulReleased", held, 3'b000);

    // Release glitch on start
    applyStimulus(1'b0, 1'b0, 1'b1);
    kEdge = edgeCount + 1;
    pushExp(kEdge + 2 + DEB, 3'b100);
    seenHeld = 1'b0;
    for (int i = 0; i < 20 && !seenHeld; i++) begin
      @(negedge clk);
      seenHeld = held[2];
    end
    checkOutput("glitchHeldReached", {2'b00, seenHeld}, 3'b001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (15) begin
      @(negedge clk);
      checkOutput("glitchHeld", held, 3'b100);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("glitchReleased", held, 3'b000);

    // Reset while p1 is in PRESS_CHK, button kept pressed
    applyStimulus(1'b1, 1'b0, 1'b0);
    kEdge = edgeCount + 1;
    waitToEdge(kEdge + 3);
    clr = 1'b0;
    #1;
    checkOutput("midResetPulses", {start, player2, player1}, 3'b000);
    checkOutput("midResetHeld", held, 3'b000);
    @(negedge clk);
    clr = 1'b1;
    kEdge = edgeCount + 1;
    pushExp(kEdge + 2 + DEB, 3'b001);
    waitToEdge(kEdge + 2 + DEB);
    checkOutput("afterResetHeld", held, 3'b001);

    // Reset while the pulse is high, then the still-pressed button re-presses
    #2;
    clr = 1'b0;
    #1;
    checkOutput("pulseResetPulses", {start, player2, player1}, 3'b000);
    checkOutput("pulseResetHeld", held, 3'b000);
    @(negedge clk);
    clr = 1'b1;
    kEdge = edgeCount + 1;
    pushExp(kEdge + 2 + DEB, 3'b001);
    waitToEdge(kEdge + 2 + DEB);
    checkOutput("repressHeld", held, 3'b001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("finalHeld", held, 3'b000);

    while (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL leftoverExpected: mask %b after edge %0d never seen",
               expQ[0].mask, expQ[0].edgeNo);
      void'(expQ.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
